// File: rtl/uart_rx_fifo_pkg.sv
// Shared oversampling constants, receiver state encoding and divisor helpers
// for the UART receive path.
package uart_rx_fifo_pkg;

  localparam int unsigned OSR      = 16;
  localparam int unsigned SAMPLE_A = 7;
  localparam int unsigned SAMPLE_B = 8;
  localparam int unsigned SAMPLE_C = 9;
  localparam int unsigned LAST_SUB = OSR - 1;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP,
    RX_BREAK
  } rx_state_e;

  // Rounded clocks-per-tick so the 16x tick tracks the line rate as closely as possible.
  function automatic int unsigned calcDiv(input int unsigned clkFreq, input int unsigned baud);
    return (clkFreq + 8 * baud) / (OSR * baud);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Consumer-facing bundle of the UART receiver: serial input, pop handshake,
// FIFO head/occupancy and the error pulses.
interface uart_rx_fifo_if #(
  parameter int DEPTH = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          rx;
  logic          rd_en;
  logic          valid;
  logic [7:0]    data;
  logic [CW-1:0] count;
  logic          frame_err;
  logic          overrun;

  modport slave (
    input  rx,
    input  rd_en,
    output valid,
    output data,
    output count,
    output frame_err,
    output overrun
  );

  modport master (
    output rx,
    output rd_en,
    input  valid,
    input  data,
    input  count,
    input  frame_err,
    input  overrun
  );

endinterface

// File: rtl/uart_rx_fifo_sync_fifo.sv
// Show-ahead FIFO: the head entry is always visible, pops and pushes may
// share a cycle, and a push into a full FIFO is kept only alongside a pop.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push_i,
  input  logic [WIDTH-1:0] pushData_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] headData_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  logic [CW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             popOk;
  logic             pushOk;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty_o    = (wrPtr_q == rdPtr_q);
  assign full_o     = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
  assign count_o    = wrPtr_q - rdPtr_q;
  assign popOk      = pop_i && !empty_o;
  assign pushOk     = push_i && (!full_o || popOk);
  assign headData_o = empty_o ? '0 : mem_q[rdPtr_q[AW-1:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (pushOk) wrPtr_d = wrPtr_q + CW'(1);
    if (popOk)  rdPtr_d = rdPtr_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (pushOk) mem_q[wrPtr_q[AW-1:0]] <= pushData_i;
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting,
// feeding received bytes into a show-ahead FIFO with error pulses.
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int unsigned CLKFREQ = 100_000_000,
  parameter int unsigned BAUD    = 115_200,
  parameter int          DEPTH   = 16
) (
  input logic            clk,
  input logic            rst_n,
  uart_rx_fifo_if.slave  bus
);

  localparam int unsigned DIV = calcDiv(CLKFREQ, BAUD);
  localparam int          TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int          CW  = $clog2(DEPTH) + 1;

  rx_state_e      state_q, state_d;
  logic           rxMeta_q, rxs_q;
  logic [TW-1:0]  tickCnt_q, tickCnt_d;
  logic [3:0]     sub_q, sub_d;
  logic [2:0]     bitIdx_q, bitIdx_d;
  logic [7:0]     shift_q, shift_d;
  logic [1:0]     samples_q, samples_d;
  logic           frameErr_q, overrun_q;

  logic           tick;
  logic           vote;
  logic           push;
  logic           frameErrSet;
  logic           fifoFull;
  logic           fifoEmpty;
  logic           popAccepted;
  logic           dropByte;
  logic [7:0]     headData;
  logic [CW-1:0]  fifoCount;

  assign tick = (tickCnt_q == TW'(DIV - 1));
  assign vote = majority3(samples_q[0], samples_q[1], rxs_q);

  // The third vote is the live synchronised sample taken on the sub==9 tick itself.
  always_comb begin
    state_d     = state_q;
    tickCnt_d   = tickCnt_q;
    sub_d       = sub_q;
    bitIdx_d    = bitIdx_q;
    shift_d     = shift_q;
    samples_d   = samples_q;
    push        = 1'b0;
    frameErrSet = 1'b0;

    if (state_q == RX_START || state_q == RX_DATA || state_q == RX_STOP) begin
      tickCnt_d = tick ? '0 : tickCnt_q + TW'(1);
      if (tick) begin
        sub_d = sub_q + 4'd1;
        if (sub_q == 4'(SAMPLE_A)) samples_d[0] = rxs_q;
        if (sub_q == 4'(SAMPLE_B)) samples_d[1] = rxs_q;
      end
    end

    case (state_q)
      RX_IDLE: begin
        if (!rxs_q) begin
          state_d   = RX_START;
          tickCnt_d = '0;
          sub_d     = '0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (sub_q == 4'(SAMPLE_C) && vote) begin
            state_d = RX_IDLE;
          end else if (sub_q == 4'(LAST_SUB)) begin
            state_d  = RX_DATA;
            bitIdx_d = '0;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (sub_q == 4'(SAMPLE_C)) shift_d = {vote, shift_q[7:1]};
          if (sub_q == 4'(LAST_SUB)) begin
            if (bitIdx_q == 3'd7) state_d = RX_STOP;
            else                  bitIdx_d = bitIdx_q + 3'd1;
          end
        end
      end
      RX_STOP: begin
        // Leaving mid stop bit leaves room to catch a back-to-back start edge.
        if (tick && sub_q == 4'(SAMPLE_C)) begin
          if (vote) begin
            push    = 1'b1;
            state_d = RX_IDLE;
          end else begin
            frameErrSet = 1'b1;
            state_d     = RX_BREAK;
          end
        end
      end
      RX_BREAK: begin
        if (rxs_q) state_d = RX_IDLE;
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxMeta_q   <= 1'b1;
      rxs_q      <= 1'b1;
      state_q    <= RX_IDLE;
      tickCnt_q  <= '0;
      sub_q      <= '0;
      bitIdx_q   <= '0;
      shift_q    <= '0;
      samples_q  <= '0;
      frameErr_q <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      rxMeta_q   <= bus.rx;
      rxs_q      <= rxMeta_q;
      state_q    <= state_d;
      tickCnt_q  <= tickCnt_d;
      sub_q      <= sub_d;
      bitIdx_q   <= bitIdx_d;
      shift_q    <= shift_d;
      samples_q  <= samples_d;
      frameErr_q <= frameErrSet;
      overrun_q  <= dropByte;
    end
  end

  assign popAccepted = bus.rd_en && !fifoEmpty;
  assign dropByte    = push && fifoFull && !popAccepted;

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (push),
    .pushData_i (shift_q),
    .pop_i      (bus.rd_en),
    .headData_o (headData),
    .full_o     (fifoFull),
    .empty_o    (fifoEmpty),
    .count_o    (fifoCount)
  );

  assign bus.valid     = !fifoEmpty;
  assign bus.data      = headData;
  assign bus.count     = fifoCount;
  assign bus.frame_err = frameErr_q;
  assign bus.overrun   = overrun_q;

endmodule
